// File: rtl/payload_tx_pkg.sv
// Shared types for the frame link transmit path.
// Frame type codes, config record and payload word.
package payload_tx_pkg;

  localparam logic [1:0] FRAME_TYPE_IDLE     = 2'd0;
  localparam logic [1:0] FRAME_TYPE_PULSE_ID = 2'd1;
  localparam logic [1:0] FRAME_TYPE_DELAY    = 2'd2;

  typedef struct packed {
    logic [7:0]  board;
    logic [7:0]  channel;
    logic [31:0] delay;
    logic [15:0] length;
    logic [15:0] divider;
    logic [15:0] modulus;
    logic [7:0]  status;
  } delay_data_t;

  typedef struct packed {
    logic [1:0]   payload_type;
    logic [127:0] data;
  } payload_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  function automatic logic [127:0] widen(input delay_data_t d);
    return {{(128 - $bits(delay_data_t)){1'b0}}, d};
  endfunction

endpackage

// File: rtl/payload_tx_fifo.sv
// Synchronous config queue of delay_data_t records.
// Full/empty come from the registered level only.
module payload_tx_fifo
  import payload_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  delay_data_t             data_i,
  input  logic                    pop_i,
  output delay_data_t             data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  delay_data_t   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;

  // pointer and level next-state
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // pointer and level registers, flushed by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/payload_tx.sv
// Frame link transmitter: slot schedule, pulse id, config queue.
// Optional PAYLOAD_TX_STATS_EN adds frame counters.
module payload_tx
  import payload_tx_pkg::*;
#(
  parameter int FRAME_PERIOD     = 64,
  parameter int FRAMES_PER_PULSE = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  delay_data_t                  cfg_data_i,
  input  logic                         pulse_id_load_i,
  input  logic [31:0]                  pulse_id_i,
  output payload_t                     payload_o,
  output logic                         frame_tick_o,
  output logic [31:0]                  pulse_id_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
`ifdef PAYLOAD_TX_STATS_EN
  ,
  output logic [31:0]                  cfg_frames_o,
  output logic [31:0]                  idle_frames_o
`endif
);

  localparam int CW = $clog2(FRAME_PERIOD);
  localparam int SW = $clog2(FRAMES_PER_PULSE);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [31:0]   pid_q, pid_d;
  payload_t      pay_q, pay_d;
  logic          tick_q, tick_d;
  logic          pid_inc;
  logic          pop;
  logic          sel_cfg;
  logic          sel_idle;

  delay_data_t   head;
  logic          full;
  logic          empty;

  payload_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cfg_valid_i),
    .data_i  (cfg_data_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );

  assign cfg_ready_o  = ~full;
  assign payload_o    = pay_q;
  assign frame_tick_o = tick_q;
  assign pulse_id_o   = pid_q;

  // schedule FSM, counters and payload mux
  always_comb begin
    state_d  = enable_i ? ST_RUN : ST_IDLE;
    cnt_d    = '0;
    slot_d   = '0;
    pay_d    = '0;
    tick_d   = 1'b0;
    pop      = 1'b0;
    pid_inc  = 1'b0;
    sel_cfg  = 1'b0;
    sel_idle = 1'b0;
    if (state_q == ST_RUN && enable_i) begin
      pay_d  = pay_q;
      slot_d = slot_q;
      cnt_d  = (cnt_q == CW'(FRAME_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
      if (cnt_q == CW'(FRAME_PERIOD - 2)) begin
        tick_d = 1'b1;
        unique case (1'b1)
          (slot_q == '0): begin
            pay_d   = '{FRAME_TYPE_PULSE_ID, {96'd0, pid_q}};
            pid_inc = 1'b1;
          end
          (slot_q != '0 && !empty): begin
            pay_d   = '{FRAME_TYPE_DELAY, widen(head)};
            pop     = 1'b1;
            sel_cfg = 1'b1;
          end
          default: begin
            pay_d    = '{FRAME_TYPE_IDLE, 128'd0};
            sel_idle = 1'b1;
          end
        endcase
      end
      if (cnt_q == CW'(FRAME_PERIOD - 1)) begin
        slot_d = (slot_q == SW'(FRAMES_PER_PULSE - 1)) ? '0 : slot_q + SW'(1);
      end
    end
  end

  // pulse id: a load beats the post-selection increment
  always_comb begin
    pid_d = pid_q;
    if (pulse_id_load_i) pid_d = pulse_id_i;
    else if (pid_inc)    pid_d = pid_q + 32'd1;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      pid_q   <= '0;
      pay_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      pid_q   <= pid_d;
      pay_q   <= pay_d;
      tick_q  <= tick_d;
    end
  end

`ifdef PAYLOAD_TX_STATS_EN
  logic [31:0] cfgc_q, cfgc_d;
  logic [31:0] idlec_q, idlec_d;

  assign cfg_frames_o  = cfgc_q;
  assign idle_frames_o = idlec_q;

  // frame statistics, counted at the edge that raises the tick
  always_comb begin
    cfgc_d  = cfgc_q + {31'd0, sel_cfg};
    idlec_d = idlec_q + {31'd0, sel_idle};
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cfgc_q  <= '0;
      idlec_q <= '0;
    end else begin
      cfgc_q  <= cfgc_d;
      idlec_q <= idlec_d;
    end
  end
`endif

endmodule

// File: tb/tb_payload_tx.sv
// Bench for payload_tx: directed table, corner sequences,
// random traffic against a frame-level reference model.
module tb_payload_tx;
  import payload_tx_pkg::*;

  localparam int FP    = 8;
  localparam int FPP   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  delay_data_t cfg_data_i;
  logic        pulse_id_load_i;
  logic [31:0] pulse_id_i;
  payload_t    payload_o;
  logic        frame_tick_o;
  logic [31:0] pulse_id_o;
  logic [3:0]  fifo_level_o;
`ifdef PAYLOAD_TX_STATS_EN
  logic [31:0] cfg_frames_o;
  logic [31:0] idle_frames_o;
`endif

  payload_tx #(
    .FRAME_PERIOD     (FP),
    .FRAMES_PER_PULSE (FPP),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_i        (enable_i),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_data_i      (cfg_data_i),
    .pulse_id_load_i (pulse_id_load_i),
    .pulse_id_i      (pulse_id_i),
    .payload_o       (payload_o),
    .frame_tick_o    (frame_tick_o),
    .pulse_id_o      (pulse_id_o),
    .fifo_level_o    (fifo_level_o)
`ifdef PAYLOAD_TX_STATS_EN
    ,
    .cfg_frames_o    (cfg_frames_o),
    .idle_frames_o   (idle_frames_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: run-cycle count, queue, pulse id
  bit          m_run;
  int          m_n;
  delay_data_t m_q[$];
  logic [31:0] m_pid;
  payload_t    m_pay;
  bit          m_tick;
  logic [31:0] m_cfg;
  logic [31:0] m_idle;

  typedef struct {
    int          n;
    bit          en;
    bit          ld;
    logic [31:0] lid;
    logic [1:0]  typ;
    logic [127:0] data;
    bit          tick;
    logic [31:0] pid;
    int          lvl;
    string       nm;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [159:0] a,
                     input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit push,
                            input delay_data_t d, input bit ld,
                            input logic [31:0] lid);
    bit acc;
    bit inc;
    delay_data_t h;
    acc = push && (m_q.size() < DEPTH);
    inc = 0;
    m_tick = 0;
    if (rst) begin
      m_run = 0; m_n = 0; m_q.delete(); m_pid = 0;
      m_pay = '0; m_cfg = 0; m_idle = 0;
      return;
    end
    if (!en) begin
      m_run = 0;
      m_pay = '0;
    end else if (!m_run) begin
      m_run = 1;
      m_n = 0;
    end else begin
      m_n++;
      if (m_n % FP == FP - 1) begin
        m_tick = 1;
        if ((m_n / FP) % FPP == 0) begin
          m_pay.payload_type = FRAME_TYPE_PULSE_ID;
          m_pay.data = {96'd0, m_pid};
          inc = 1;
        end else if (m_q.size() != 0) begin
          h = m_q.pop_front();
          m_pay.payload_type = FRAME_TYPE_DELAY;
          m_pay.data = {24'd0, h};
          m_cfg++;
        end else begin
          m_pay = '0;
          m_idle++;
        end
      end
    end
    if (ld) m_pid = lid;
    else if (inc) m_pid = m_pid + 1;
    if (acc) m_q.push_back(d);
  endtask

  task automatic step(input bit rst, input bit en, input bit push,
                      input delay_data_t d, input bit ld,
                      input logic [31:0] lid);
    reset = rst;
    enable_i = en;
    cfg_valid_i = push;
    cfg_data_i = d;
    pulse_id_load_i = ld;
    pulse_id_i = lid;
    @(posedge clk);
    model_edge(rst, en, push, d, ld, lid);
    #1;
    chk("payload", 160'(payload_o), 160'(m_pay));
    chk("tick", 160'(frame_tick_o), 160'(m_tick));
    chk("pulse_id", 160'(pulse_id_o), 160'(m_pid));
    chk("level", 160'(fifo_level_o), 160'(m_q.size()));
    chk("ready", 160'(cfg_ready_o), 160'(m_q.size() < DEPTH));
`ifdef PAYLOAD_TX_STATS_EN
    chk("cfg_frames", 160'(cfg_frames_o), 160'(m_cfg));
    chk("idle_frames", 160'(idle_frames_o), 160'(m_idle));
`endif
  endtask

  function automatic delay_data_t rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return delay_data_t'(r[$bits(delay_data_t)-1:0]);
  endfunction

  task automatic run(input int n, input bit en);
    repeat (n) step(0, en, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
  endtask

  initial begin
    delay_data_t e2;
    int c0, c1, c2;
    logic [31:0] pid_before;

    reset = 1; enable_i = 0; cfg_valid_i = 0; cfg_data_i = '0;
    pulse_id_load_i = 0; pulse_id_i = 0;

    vt[0]  = '{1,  0, 0, 0, 2'd0, 128'd0, 0, 32'd0, 0, "reset_idle"};
    vt[1]  = '{8,  1, 0, 0, 2'd1, 128'd0, 1, 32'd1, 0, "tick1_id0"};
    vt[2]  = '{8,  1, 0, 0, 2'd0, 128'd0, 1, 32'd1, 0, "tick2_idle"};
    vt[3]  = '{8,  1, 0, 0, 2'd0, 128'd0, 1, 32'd1, 0, "tick3_idle"};
    vt[4]  = '{8,  1, 0, 0, 2'd0, 128'd0, 1, 32'd1, 0, "tick4_idle"};
    vt[5]  = '{8,  1, 0, 0, 2'd1, 128'd1, 1, 32'd2, 0, "tick5_id1"};
    vt[6]  = '{1,  1, 0, 0, 2'd1, 128'd1, 0, 32'd2, 0, "hold"};
    vt[7]  = '{1,  1, 1, 32'hFFFF_FFFF, 2'd1, 128'd1, 0,
               32'hFFFF_FFFF, 0, "load"};
    vt[8]  = '{30, 1, 0, 0, 2'd1, 128'hFFFF_FFFF, 1, 32'd0, 0, "wrap_ff"};
    vt[9]  = '{32, 1, 0, 0, 2'd1, 128'd0, 1, 32'd1, 0, "wrap_00"};
    vt[10] = '{1,  0, 0, 0, 2'd0, 128'd0, 0, 32'd1, 0, "disable_clear"};

    // directed schedule and pulse id wrap
    do_reset();
    chk("reset_ready", 160'(cfg_ready_o), 160'(1));
    for (int i = 0; i < 11; i++) begin
      repeat (vt[i].n)
        step(0, vt[i].en, 0, '0, vt[i].ld, vt[i].lid);
      chk({vt[i].nm, "_type"}, 160'(payload_o.payload_type),
          160'(vt[i].typ));
      chk({vt[i].nm, "_data"}, 160'(payload_o.data), 160'(vt[i].data));
      chk({vt[i].nm, "_tick"}, 160'(frame_tick_o), 160'(vt[i].tick));
      chk({vt[i].nm, "_pid"}, 160'(pulse_id_o), 160'(vt[i].pid));
      chk({vt[i].nm, "_lvl"}, 160'(fifo_level_o), 160'(vt[i].lvl));
    end

    // single config entry lands in the second frame
    do_reset();
    e2 = '{8'd1, 8'd1, 32'd100, 16'd20, 16'd2, 16'd0, 8'd1};
    run(3, 1);
    step(0, 1, 1, e2, 0, 0);
    run(12, 1);
    chk("cfg_type", 160'(payload_o.payload_type), 160'(FRAME_TYPE_DELAY));
    chk("cfg_data", 160'(payload_o.data), 160'({24'd0, e2}));
    chk("cfg_tick", 160'(frame_tick_o), 160'(1));
    chk("cfg_level", 160'(fifo_level_o), 160'(0));

    // fill to full while idle, then drain through slots 1-3
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 1, rnd_data(), 0, 0);
    chk("full_ready", 160'(cfg_ready_o), 160'(0));
    chk("full_level", 160'(fifo_level_o), 160'(8));
    step(0, 0, 1, rnd_data(), 0, 0);
    chk("ninth_level", 160'(fifo_level_o), 160'(8));
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 12 * FP; i++) begin
      step(0, 1, 0, '0, 0, 0);
      if (frame_tick_o) begin
        if (payload_o.payload_type == FRAME_TYPE_IDLE) c0++;
        if (payload_o.payload_type == FRAME_TYPE_PULSE_ID) c1++;
        if (payload_o.payload_type == FRAME_TYPE_DELAY) c2++;
      end
    end
    chk("drain_type2", 160'(c2), 160'(8));
    chk("drain_type1", 160'(c1), 160'(3));
    chk("drain_type0", 160'(c0), 160'(1));

    // reset mid-frame with queued entries
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, rnd_data(), 0, 0);
    run(3, 1);
    step(1, 1, 0, '0, 0, 0);
    chk("rst_payload", 160'(payload_o), 160'(0));
    chk("rst_tick", 160'(frame_tick_o), 160'(0));
    chk("rst_level", 160'(fifo_level_o), 160'(0));
    chk("rst_ready", 160'(cfg_ready_o), 160'(1));
    run(8, 1);
    chk("rst_reen_type", 160'(payload_o.payload_type),
        160'(FRAME_TYPE_PULSE_ID));
    chk("rst_reen_data", 160'(payload_o.data), 160'(0));

    // enable dropped at counter 6, then resumed
    do_reset();
    step(0, 0, 0, '0, 1, 32'h1234);
    run(8, 1);
    run(7, 1);
    pid_before = m_pid;
    step(0, 0, 0, '0, 0, 0);
    chk("drop_tick", 160'(frame_tick_o), 160'(0));
    run(8, 1);
    chk("resume_tick", 160'(frame_tick_o), 160'(1));
    chk("resume_type", 160'(payload_o.payload_type),
        160'(FRAME_TYPE_PULSE_ID));
    chk("resume_id", 160'(payload_o.data), 160'({96'd0, 32'h1235}));
    chk("resume_pid", 160'(pid_before), 160'(32'h1235));

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 799) == 0),
           ($urandom_range(0, 199) != 0),
           ($urandom_range(0, 5) == 0),
           rnd_data(),
           ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFE : $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
